sccb_slave: RTL

SCCB_SLAVE -- requirements
Module: sccb_slave

---
 rtl/sccb_pkg.sv | 11 +
 rtl/sccb_line_filter.sv | 53 +++++
 rtl/sccb_slave.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sccb_pkg.sv
// Shared SCCB slave definitions: FSM state encoding and default parameters.
package sccb_pkg;

    localparam logic [7:0]  DEF_DEV_ID = 8'h78;
    localparam int unsigned DEF_FILT   = 3;

    typedef enum logic [3:0] {
        IDLE, ID, ID_ACK, AH, AH_ACK, AL, AL_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK, IGNORE
    } sccb_state_e;

endpackage

// File: rtl/sccb_line_filter.sv
// Synchronizes and de-glitches scl/sda, then flags scl edges and START/STOP conditions.
module sccb_line_filter
    import sccb_pkg::*;
#(
    parameter int unsigned FILT = DEF_FILT
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda_in,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0]      scl_sync, sda_sync;
    logic [FILT-1:0] scl_hist, sda_hist;
    logic            scl_q, sda_q, scl_p, sda_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda_in};
            scl_hist <= (scl_hist << 1) | FILT'(scl_sync[1]);
            sda_hist <= (sda_hist << 1) | FILT'(sda_sync[1]);
            // A level only changes once FILT consecutive samples agree.
            if (&scl_hist) scl_q <= 1'b1;
            else if (scl_hist == '0) scl_q <= 1'b0;
            if (&sda_hist) sda_q <= 1'b1;
            else if (sda_hist == '0) sda_q <= 1'b0;
            scl_p <= scl_q;
            sda_p <= sda_q;
        end
    end

    assign sda_f    = sda_q;
    assign scl_rise = scl_q & ~scl_p;
    assign scl_fall = ~scl_q & scl_p;
    assign start    = scl_q & scl_p & sda_p & ~sda_q;
    assign stop     = scl_q & scl_p & ~sda_p & sda_q;

endmodule

// File: rtl/sccb_slave.sv
// SCCB register-access slave with 16-bit addressing and auto-increment.
// Define SCCB_SLAVE_READ_EN to enable the read path (RDAT/RDAT_ACK).
module sccb_slave
    import sccb_pkg::*;
#(
    parameter logic [7:0]  DEV_ID = DEF_DEV_ID,
    parameter int unsigned FILT   = DEF_FILT
) (
    input  logic        sclk_50m,
    input  logic        s_rst,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic        wr_vld,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        busy
);

    logic sda_f, scl_rise, scl_fall, start, stop;

    sccb_line_filter #(.FILT(FILT)) u_filter (
        .clk      (sclk_50m),
        .rst      (s_rst),
        .scl      (scl),
        .sda_in   (sda_in),
        .sda_f    (sda_f),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    sccb_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  sh_q, sh_d;
    logic        oe_q, oe_d, rw_q, rw_d, ack_q, ack_d, wr_vld_q, wr_vld_d, busy_q, busy_d;
    logic [15:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;

    always_ff @(posedge sclk_50m or posedge s_rst) begin
        if (s_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            oe_q      <= 1'b0;
            rw_q      <= 1'b0;
            ack_q     <= 1'b0;
            wr_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            oe_q      <= oe_d;
            rw_q      <= rw_d;
            ack_q     <= ack_d;
            wr_vld_q  <= wr_vld_d;
            busy_q    <= busy_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        oe_d      = oe_q;
        rw_d      = rw_q;
        ack_d     = ack_q;
        wr_vld_d  = 1'b0;
        busy_d    = busy_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        wr_data_d = wr_data_q;
        // Address advances the cycle after the strobe so wr_addr is stable with wr_vld.
        if (wr_vld_q) begin
            wr_addr_d = wr_addr_q + 16'd1;
`ifdef SCCB_SLAVE_READ_EN
            rd_addr_d = rd_addr_q + 16'd1;
`endif
        end
        if (stop) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start) begin
            state_d = ID;
            cnt_d   = '0;
            oe_d    = 1'b0;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                ID, AH, AL, WDAT: begin
                    if (scl_rise) begin
                        sh_d  = {sh_q[6:0], sda_f};
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d = '0;
                        oe_d  = 1'b1;
                        if (state_q == ID) begin
                            if (sh_q == DEV_ID) begin
                                rw_d    = 1'b0;
                                state_d = ID_ACK;
                            end
`ifdef SCCB_SLAVE_READ_EN
                            else if (sh_q == (DEV_ID | 8'h01)) begin
                                rw_d    = 1'b1;
                                state_d = ID_ACK;
                            end
`endif
                            else begin
                                oe_d    = 1'b0;
                                state_d = IGNORE;
                            end
                        end else if (state_q == AH) begin
                            wr_addr_d[15:8] = sh_q;
                            state_d         = AH_ACK;
                        end else if (state_q == AL) begin
                            wr_addr_d[7:0] = sh_q;
`ifdef SCCB_SLAVE_READ_EN
                            rd_addr_d      = {wr_addr_q[15:8], sh_q};
`endif
                            state_d        = AL_ACK;
                        end else begin
                            wr_data_d = sh_q;
                            state_d   = WDAT_ACK;
                        end
                    end
                end
                ID_ACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = AH;
`ifdef SCCB_SLAVE_READ_EN
                        if (rw_q) begin
                            state_d = RDAT;
                            sh_d    = rd_data;
                            oe_d    = ~rd_data[7];
                        end
`endif
                    end
                end
                AH_ACK: if (scl_fall) begin
                    oe_d    = 1'b0;
                    state_d = AL;
                end
                AL_ACK: if (scl_fall) begin
                    oe_d    = 1'b0;
                    state_d = WDAT;
                end
                WDAT_ACK: if (scl_fall) begin
                    oe_d     = 1'b0;
                    wr_vld_d = 1'b1;
                    state_d  = WDAT;
                end
`ifdef SCCB_SLAVE_READ_EN
                RDAT: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d   = '0;
                        oe_d    = 1'b0;
                        state_d = RDAT_ACK;
                    end else if (scl_fall && cnt_q != 4'd0) begin
                        oe_d = ~sh_q[6];
                        sh_d = {sh_q[6:0], 1'b0};
                    end
                end
                RDAT_ACK: begin
                    // Bump the address on the ACK clock so rd_data is current at the next load.
                    if (scl_rise) begin
                        ack_d = ~sda_f;
                        if (!sda_f) rd_addr_d = rd_addr_q + 16'd1;
                    end else if (scl_fall) begin
                        if (ack_q) begin
                            state_d = RDAT;
                            cnt_d   = '0;
                            sh_d    = rd_data;
                            oe_d    = ~rd_data[7];
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

`ifndef SCCB_SLAVE_READ_EN
    logic unused_rd;
    assign unused_rd = ^{rd_data, ack_q, rw_q};
`endif

    assign sda_oe  = oe_q;
    assign wr_vld  = wr_vld_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_addr = rd_addr_q;
    assign busy    = busy_q;

endmodule
